uart_tx_scheduler: RTL and testbench

Frame-atomic scheduler that shares the single UART transmit byte engine between `NUM_REQ` byte-stream requesters, such as the response-frame builder and the status reporter. It sits between the requesters and the TX engine, which drives `uart_tx` and reports `tx_busy`. Arbitration is round-robin at frame granularity. Byte launches are gated by the hardware flow-control input `uart_cts_n`, and the block publishes frame-boundary pulses for monitoring.

---
 rtl/uart_ctrl_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/uart_tx_scheduler.sv | 153 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types for the UART transmit control path: scheduler state encoding
// and the byte width used by every byte-stream interface.
package uart_ctrl_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LAUNCH  = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } tx_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after
// last_grant, wrapping around, as a one-hot vector plus its index.
module rr_arbiter #(
  parameter  int N   = 2,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  logic found;

  // Two passes: indices above last_grant first, then the wrapped low half.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (IDW'(i) > last_grant)) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = IDW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (IDW'(i) <= last_grant)) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Frame-atomic round-robin scheduler sharing one UART TX byte engine between
// NUM_REQ requesters, with CTS flow control and a saturating stall monitor.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter  int          NUM_REQ         = 2,
  parameter  int          CTS_SYNC_STAGES = 2,
  parameter  logic [15:0] STALL_LIMIT     = 16'd50000,
  localparam int          IDW             = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [UART_BYTE_W-1:0]         tx_data,
  input  logic                           tx_busy,
  input  logic                           uart_cts_n,
  output logic                           grant_active,
  output logic [IDW-1:0]                 grant_id,
  output logic                           frame_start,
  output logic                           frame_end,
  output logic                           cts_stall,
  output tx_sched_state_t                dbg_state_o
);

  tx_sched_state_t              state_q;
  logic [IDW-1:0]               grant_id_q, last_grant_q;
  logic                         grant_active_q, is_last_q, first_q;
  logic                         tx_start_q, frame_start_q;
  logic [UART_BYTE_W-1:0]       tx_data_q;
  logic [15:0]                  stall_cnt_q, stall_cnt_d;
  logic [CTS_SYNC_STAGES-1:0]   cts_sync_q;

  logic [NUM_REQ-1:0]           arb_gnt;
  logic [IDW-1:0]               arb_id;
  logic [UART_BYTE_W-1:0]       req_bytes [NUM_REQ];
  logic                         own_valid, own_last, cts_ok, handshake;
  logic [UART_BYTE_W-1:0]       own_data;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .gnt_id     (arb_id)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[i*UART_BYTE_W +: UART_BYTE_W];
    end
  end

  assign own_valid = req_valid[grant_id_q];
  assign own_last  = req_last[grant_id_q];
  assign own_data  = req_bytes[grant_id_q];
  assign cts_ok    = ~cts_sync_q[CTS_SYNC_STAGES-1];

  // Handshake: a byte moves when the owner's req_valid and our req_ready are
  // both high on a rising edge; ready only ever appears in FETCH for the owner.
  assign handshake = (state_q == FETCH) && own_valid && cts_ok;

  always_comb begin
    req_ready           = '0;
    req_ready[grant_id_q] = handshake;
  end

  // Completion is reported in the very cycle busy is seen low, hence decoded.
  assign frame_end    = (state_q == WAIT_LO) && !tx_busy && is_last_q;
  assign tx_start     = tx_start_q;
  assign frame_start  = frame_start_q;
  assign tx_data      = tx_data_q;
  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;
  assign cts_stall    = (stall_cnt_q >= STALL_LIMIT);
  assign dbg_state_o  = state_q;

  // Synchronizer resets to "CTS deasserted" so nothing launches before it fills.
  always_ff @(posedge clk) begin
    if (!rst_n) cts_sync_q <= '1;
    else        cts_sync_q <= {cts_sync_q[CTS_SYNC_STAGES-2:0], uart_cts_n};
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (handshake) begin
      stall_cnt_d = '0;
    end else if ((state_q == FETCH) && own_valid && !cts_ok && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      grant_id_q     <= '0;
      last_grant_q   <= IDW'(NUM_REQ - 1);
      grant_active_q <= 1'b0;
      is_last_q      <= 1'b0;
      first_q        <= 1'b0;
      tx_start_q     <= 1'b0;
      frame_start_q  <= 1'b0;
      tx_data_q      <= '0;
    end else begin
      tx_start_q    <= 1'b0;
      frame_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|arb_gnt) begin
            grant_id_q     <= arb_id;
            grant_active_q <= 1'b1;
            first_q        <= 1'b1;
            state_q        <= FETCH;
          end
        end
        FETCH: begin
          if (handshake) begin
            tx_data_q     <= own_data;
            is_last_q     <= own_last;
            tx_start_q    <= 1'b1;
            frame_start_q <= first_q;
            first_q       <= 1'b0;
            state_q       <= LAUNCH;
          end
        end
        LAUNCH: state_q <= WAIT_HI;
        WAIT_HI: begin
          if (tx_busy) state_q <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (is_last_q) begin
              last_grant_q   <= grant_id_q;
              grant_active_q <= 1'b0;
              state_q        <= IDLE;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: requester drivers, a TX engine model,
// and a scoreboard monitor comparing each launched byte and frame end.
module tb_uart_tx_scheduler;
  import uart_ctrl_pkg::*;

  logic            clk, rst_n;
  logic [1:0]      req_valid, req_last, req_ready;
  logic [15:0]     req_data;
  logic            tx_start, tx_busy, uart_cts_n;
  logic [7:0]      tx_data;
  logic            grant_active, frame_start, frame_end, cts_stall;
  logic [0:0]      grant_id;
  tx_sched_state_t dbg_state;

  logic [8:0] src_q [2][$];
  logic [9:0] exp_q[$];
  logic [0:0] exp_end_q[$];
  logic [1:0] en;
  int         total, bad;

  uart_tx_scheduler #(.NUM_REQ(2), .CTS_SYNC_STAGES(2), .STALL_LIMIT(16'd20)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .uart_cts_n(uart_cts_n),
    .grant_active(grant_active), .grant_id(grant_id), .frame_start(frame_start),
    .frame_end(frame_end), .cts_stall(cts_stall), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, want, $time);
    end
  endtask

  // ---------------- drivers ----------------
  initial begin
    logic [1:0] hs;
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        req_valid[i] = en[i] && (src_q[i].size() > 0);
        req_data[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0][7:0] : 8'h00;
        req_last[i] = (src_q[i].size() > 0) ? src_q[i][0][8] : 1'b0;
      end
    end
  end

  // TX engine: busy rises one cycle after the launch and stays high four cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  task automatic src_push(input int id, input logic [7:0] d, input logic last);
    src_q[id].push_back({last, d});
  endtask

  task automatic exp_push(input logic fs, input logic id, input logic [7:0] d);
    exp_q.push_back({fs, id, d});
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [9:0] e;
    logic [0:0] ee;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_start) begin
          chk("start_while_busy", tx_busy, 0);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected act=%0h exp=none", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte{fs,id,data}", {frame_start, grant_id, tx_data}, e);
          end
        end else if (frame_start) begin
          total++; bad++;
          $display("FAIL frame_start_without_launch act=1 exp=0");
        end
        if (frame_end) begin
          if (exp_end_q.size() == 0) begin
            total++; bad++;
            $display("FAIL frame_end_unexpected act=id%0d exp=none", grant_id);
          end else begin
            ee = exp_end_q.pop_front();
            chk("frame_end_id", grant_id, ee);
          end
        end
        if (req_ready != 2'b00) begin
          chk("ready_onehot", $countones(req_ready) <= 1, 1);
          chk("ready_in_fetch", dbg_state == FETCH, 1);
        end
      end
    end
  end

  // ---------------- test helpers ----------------
  task automatic check_idle(input string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_grant_active"}, grant_active, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_frame_end"}, frame_end, 0);
    chk({tag, "_cts_stall"}, cts_stall, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_tx(input logic [7:0] d);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(tx_start && tx_data == d) && n < 200);
    chk("wait_tx_seen", tx_start && tx_data == d, 1);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!grant_active && n < 100) begin @(negedge clk); n++; end
    chk("wait_grant_seen", grant_active, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() + exp_end_q.size()) != 0 && n < 400) begin @(negedge clk); n++; end
    chk("drain_pending", exp_q.size() + exp_end_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, viol;
    total = 0; bad = 0;
    rst_n = 1'b0; uart_cts_n = 1'b0; en = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Single requester, 3-byte frame
    src_push(0, 8'hA5, 0); src_push(0, 8'h01, 0); src_push(0, 8'h5A, 1);
    exp_push(1, 0, 8'hA5); exp_push(0, 0, 8'h01); exp_push(0, 0, 8'h5A);
    exp_end_q.push_back(1'b0);
    wait_drain();

    // Contention out of reset: req0 first, then req1
    do_reset();
    src_push(0, 8'h11, 0); src_push(0, 8'h12, 1);
    src_push(1, 8'h21, 0); src_push(1, 8'h22, 1);
    exp_push(1, 0, 8'h11); exp_push(0, 0, 8'h12);
    exp_push(1, 1, 8'h21); exp_push(0, 1, 8'h22);
    exp_end_q.push_back(1'b0); exp_end_q.push_back(1'b1);
    wait_drain();
    src_push(0, 8'h31, 1); exp_push(1, 0, 8'h31); exp_end_q.push_back(1'b0);
    wait_drain();
    // last owner was req0, so req1 now wins the tie
    src_push(0, 8'h41, 1); src_push(1, 8'h51, 1);
    exp_push(1, 1, 8'h51); exp_push(1, 0, 8'h41);
    exp_end_q.push_back(1'b1); exp_end_q.push_back(1'b0);
    wait_drain();

    // Flow control: CTS raised while byte 2 is on the wire
    src_push(0, 8'hC1, 0); src_push(0, 8'hC2, 0); src_push(0, 8'hC3, 1);
    exp_push(1, 0, 8'hC1); exp_push(0, 0, 8'hC2); exp_push(0, 0, 8'hC3);
    exp_end_q.push_back(1'b0);
    wait_tx(8'hC2);
    uart_cts_n = 1'b1;
    viol = 0;
    repeat (12) begin @(negedge clk); if (req_ready != 2'b00) viol++; end
    chk("cts_block_ready_cycles", viol, 0);
    chk("cts_block_state_fetch", dbg_state == FETCH, 1);
    @(posedge clk); #1 uart_cts_n = 1'b0;
    n = 0;
    while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
    chk("cts_release_latency", n, 3);
    wait_drain();

    // Stall: CTS held off with a pending byte
    uart_cts_n = 1'b1;
    repeat (4) @(negedge clk);
    src_push(0, 8'hD1, 1); exp_push(1, 0, 8'hD1); exp_end_q.push_back(1'b0);
    wait_grant();
    n = 0;
    while (!cts_stall && n < 40) begin @(negedge clk); n++; end
    chk("stall_rise_cycle", n, 20);
    repeat (5) @(negedge clk);
    chk("stall_held", cts_stall, 1);
    uart_cts_n = 1'b0;
    wait_tx(8'hD1);
    chk("stall_cleared", cts_stall, 0);
    wait_drain();

    // Owner starvation: req0 pauses mid-frame while req1 waits
    src_push(0, 8'hE1, 0); src_push(0, 8'hE2, 0); src_push(0, 8'hE3, 1);
    exp_push(1, 0, 8'hE1); exp_push(0, 0, 8'hE2); exp_push(0, 0, 8'hE3);
    exp_push(1, 1, 8'hF1);
    exp_end_q.push_back(1'b0); exp_end_q.push_back(1'b1);
    wait_grant();
    src_push(1, 8'hF1, 1);
    wait_tx(8'hE1);
    en[0] = 1'b0;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (grant_id != 1'b0 || req_ready[1] || !grant_active) viol++;
    end
    chk("starve_grant_held", viol, 0);
    en[0] = 1'b1;
    wait_drain();

    // Reset while waiting for busy: no frame_end, req0 wins afterwards
    src_push(0, 8'h71, 0); src_push(0, 8'h72, 1);
    exp_push(1, 0, 8'h71);
    wait_tx(8'h71);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("midrst");
    src_q[0].delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (tx_busy && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(posedge clk);
    src_push(0, 8'h81, 1); src_push(1, 8'h91, 1);
    exp_push(1, 0, 8'h81); exp_push(1, 1, 8'h91);
    exp_end_q.push_back(1'b0); exp_end_q.push_back(1'b1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
